// File: rtl/seg7_count_monitor.sv
// Checks a 7-segment counter display: syncs and debounces the bus, decodes digits, verifies a mod-MOD up-count.
// Status outputs are registered one cycle after a pattern is accepted; SEG7_MON_QCHECK_EN adds an iQ cross-check.
module seg7_count_monitor #(
    parameter int MOD            = 8,
    parameter int STABLE_CYC     = 4,
    parameter int SEG_ACTIVE_LOW = 0,
    parameter int ERRW           = 8,
    parameter int STEPW          = 16
) (
    input  logic             CLK,
    input  logic             rst_n,
    input  logic [6:0]       iSeg,
`ifdef SEG7_MON_QCHECK_EN
    input  logic [3:0]       iQ,
    output logic             oMismatch,
`endif
    output logic [3:0]       oValue,
    output logic             oValid,
    output logic             oLocked,
    output logic             oErr,
    output logic [ERRW-1:0]  oErrCnt,
    output logic [STEPW-1:0] oStepCnt
);

    typedef enum logic [1:0] {IDLE, TRACK, ERR} state_t;

    logic [6:0] seg_s1, seg_s2, samp, cand, acc_pat;
    logic [7:0] run;
    logic       accept;
    logic [3:0] dig, ref_dig, next_ref;
    logic       known, legal;
    logic [ERRW-1:0] err_next;
    state_t     state;

    assign samp   = (SEG_ACTIVE_LOW != 0) ? ~seg_s2 : seg_s2;
    // run saturates at STABLE_CYC; comparing against acc_pat keeps a held pattern from re-firing
    assign accept = (run == 8'(STABLE_CYC)) && (cand != acc_pat);

    always_ff @(posedge CLK or negedge rst_n) begin
        if (!rst_n) begin
            seg_s1  <= '0;
            seg_s2  <= '0;
            cand    <= '0;
            run     <= '0;
            acc_pat <= '0;
        end else begin
            seg_s1 <= iSeg;
            seg_s2 <= seg_s1;
            if (samp != cand) begin
                cand <= samp;
                run  <= 8'd1;
            end else if (run != 8'(STABLE_CYC)) begin
                run <= run + 8'd1;
            end
            if (accept)
                acc_pat <= cand;
        end
    end

    always_comb begin
        known = 1'b1;
        dig   = 4'd0;
        case (cand)
            7'h3F: dig = 4'h0;
            7'h06: dig = 4'h1;
            7'h5B: dig = 4'h2;
            7'h4F: dig = 4'h3;
            7'h66: dig = 4'h4;
            7'h6D: dig = 4'h5;
            7'h7D: dig = 4'h6;
            7'h07: dig = 4'h7;
            7'h7F: dig = 4'h8;
            7'h6F: dig = 4'h9;
            7'h77: dig = 4'hA;
            7'h7C: dig = 4'hB;
            7'h39: dig = 4'hC;
            7'h5E: dig = 4'hD;
            7'h79: dig = 4'hE;
            7'h71: dig = 4'hF;
            default: known = 1'b0;
        endcase
    end

    assign legal    = known && (int'(dig) < MOD);
    assign next_ref = (ref_dig == 4'(MOD - 1)) ? 4'd0 : ref_dig + 4'd1;
    assign err_next = (oErrCnt == '1) ? oErrCnt : oErrCnt + ERRW'(1);

`ifdef SEG7_MON_QCHECK_EN
    logic [3:0] q_s1, q_s2;

    always_ff @(posedge CLK or negedge rst_n) begin
        if (!rst_n) begin
            q_s1      <= '0;
            q_s2      <= '0;
            oMismatch <= 1'b0;
        end else begin
            q_s1      <= iQ;
            q_s2      <= q_s1;
            oMismatch <= accept && legal && (q_s2 != dig);
        end
    end
`endif

    always_ff @(posedge CLK or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            ref_dig  <= '0;
            oValue   <= '0;
            oValid   <= 1'b0;
            oLocked  <= 1'b0;
            oErr     <= 1'b0;
            oErrCnt  <= '0;
            oStepCnt <= '0;
        end else begin
            oValid <= 1'b0;
            oErr   <= 1'b0;
            if (accept) begin
                if (legal) begin
                    oValue  <= dig;
                    oValid  <= 1'b1;
                    ref_dig <= dig;
                    if (state == IDLE || dig == next_ref) begin
                        state   <= TRACK;
                        oLocked <= 1'b1;
                        if (state != IDLE)
                            oStepCnt <= oStepCnt + STEPW'(1);
                    end else begin
                        state   <= ERR;
                        oLocked <= 1'b0;
                        oErr    <= 1'b1;
                        oErrCnt <= err_next;
                    end
                end else begin
                    oErr    <= 1'b1;
                    oErrCnt <= err_next;
                    if (state != IDLE) begin
                        state   <= ERR;
                        oLocked <= 1'b0;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_seg7_count_monitor.sv
// Directed bench for seg7_count_monitor with an event-level reference model checked every cycle.
module tb_seg7_count_monitor;
    localparam int MOD = 8;
    localparam int SC  = 4;

    logic        CLK = 1'b0;
    logic        rst_n = 1'b0;
    logic [6:0]  iSeg = 7'h00;
    logic [3:0]  oValue;
    logic        oValid, oLocked, oErr;
    logic [7:0]  oErrCnt;
    logic [15:0] oStepCnt;
`ifdef SEG7_MON_QCHECK_EN
    logic [3:0]  iQ = 4'd0;
    logic        oMismatch;
    logic [3:0]  hq [3];
    logic        e_mm;
    int          nmm = 0;
`endif

    int tests = 0;
    int fails = 0;
    int nv = 0;
    int ne = 0;

    always #5 CLK = ~CLK;

    seg7_count_monitor #(.MOD(MOD), .STABLE_CYC(SC), .SEG_ACTIVE_LOW(0), .ERRW(8), .STEPW(16)) dut (
        .CLK(CLK), .rst_n(rst_n), .iSeg(iSeg),
`ifdef SEG7_MON_QCHECK_EN
        .iQ(iQ), .oMismatch(oMismatch),
`endif
        .oValue(oValue), .oValid(oValid), .oLocked(oLocked), .oErr(oErr),
        .oErrCnt(oErrCnt), .oStepCnt(oStepCnt)
    );

    logic [6:0] seg_tab [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

    // Model: a pattern is taken once the input has shown it at SC consecutive edges
    // (seen 2 edges late through the synchroniser) and it differs from the last one taken.
    logic [6:0]  hist [SC+3];
    logic [6:0]  acc;
    int          mst;          // 0 idle, 1 locked, 2 error
    int          mref;
    logic [3:0]  e_val;
    logic        e_vld, e_lck, e_err;
    logic [7:0]  e_ec;
    logic [15:0] e_sc;

    task automatic model_reset();
        for (int k = 0; k < SC + 3; k++) hist[k] = 7'h00;
        acc = 7'h00; mst = 0; mref = 0;
        e_val = 4'd0; e_vld = 1'b0; e_lck = 1'b0; e_err = 1'b0; e_ec = 8'd0; e_sc = 16'd0;
`ifdef SEG7_MON_QCHECK_EN
        for (int k = 0; k < 3; k++) hq[k] = 4'd0;
        e_mm = 1'b0;
`endif
    endtask

    task automatic model_step();
        logic stable, lg;
        int d;
        for (int k = SC + 2; k > 0; k--) hist[k] = hist[k-1];
        hist[0] = iSeg;
`ifdef SEG7_MON_QCHECK_EN
        hq[2] = hq[1]; hq[1] = hq[0]; hq[0] = iQ;
        e_mm = 1'b0;
`endif
        e_vld = 1'b0; e_err = 1'b0;
        stable = 1'b1;
        for (int k = 3; k < SC + 3; k++) if (hist[k] != hist[3]) stable = 1'b0;
        if (stable && hist[3] != acc) begin
            acc = hist[3];
            lg = 1'b0; d = 0;
            for (int k = 0; k < MOD; k++) if (seg_tab[k] == acc) begin lg = 1'b1; d = k; end
            if (lg) begin
                e_vld = 1'b1;
                e_val = 4'(d);
`ifdef SEG7_MON_QCHECK_EN
                e_mm = (int'(hq[2]) != d);
`endif
                if (mst == 0 || d == (mref + 1) % MOD) begin
                    if (mst != 0) e_sc = e_sc + 16'd1;
                    mst = 1;
                end else begin
                    mst = 2; e_err = 1'b1;
                end
                mref = d;
            end else begin
                e_err = 1'b1;
                if (mst != 0) mst = 2;
            end
            if (e_err && e_ec != 8'hFF) e_ec = e_ec + 8'd1;
            e_lck = (mst == 1);
        end
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    initial begin
        model_reset();
        forever begin
            @(posedge CLK);
            if (!rst_n) model_reset();
            else model_step();
            #1;
            tests++;
            if ({oValue, oValid, oLocked, oErr, oErrCnt, oStepCnt} !== {e_val, e_vld, e_lck, e_err, e_ec, e_sc}) begin
                fails++;
                $display("FAIL cycle t=%0t: got val=%0h vld=%b lck=%b err=%b ec=%0d sc=%0d expected val=%0h vld=%b lck=%b err=%b ec=%0d sc=%0d",
                         $time, oValue, oValid, oLocked, oErr, oErrCnt, oStepCnt, e_val, e_vld, e_lck, e_err, e_ec, e_sc);
            end
`ifdef SEG7_MON_QCHECK_EN
            tests++;
            if (oMismatch !== e_mm) begin
                fails++;
                $display("FAIL mismatch t=%0t: got %b expected %b", $time, oMismatch, e_mm);
            end
            if (oMismatch) nmm++;
`endif
            if (oValid) nv++;
            if (oErr) ne++;
        end
    end

    task automatic show(input logic [6:0] p, input int n);
        @(negedge CLK);
        iSeg = p;
        repeat (n) @(posedge CLK);
        #2;
    endtask

    logic [6:0] run_pats [9] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07, 7'h3F};
    int nv0, ne0, lat;
`ifdef SEG7_MON_QCHECK_EN
    int nmm0;
`endif

    initial begin
        repeat (3) @(posedge CLK);
        #2;
        chk("reset_state", {oValue, oValid, oLocked, oErr, oErrCnt, oStepCnt}, 32'd0);
        @(negedge CLK);
        rst_n = 1'b1;

        // full count 0..7 and wrap back to 0
        show(7'h00, 10);
        for (int i = 0; i < 9; i++) show(run_pats[i], 10);
        chk("count_valids", nv, 9);
        chk("count_steps", oStepCnt, 8);
        chk("count_errs", oErrCnt, 0);
        chk("count_locked", oLocked, 1);
        chk("count_value", oValue, 0);

        // wrong step 2 -> 4, then recovery with 5
        show(7'h06, 10);
        show(7'h5B, 10);
        show(7'h66, 10);
        chk("skip_errcnt", oErrCnt, 1);
        chk("skip_locked", oLocked, 0);
        chk("skip_value", oValue, 4);
        show(7'h6D, 10);
        chk("recover_locked", oLocked, 1);
        chk("recover_steps", oStepCnt, 11);

        // illegal pattern holds value, then correct next digit relocks
        nv0 = nv;
        show(7'h00, 10);
        chk("illegal_errcnt", oErrCnt, 2);
        chk("illegal_value", oValue, 5);
        chk("illegal_novalid", nv - nv0, 0);
        show(7'h7D, 10);
        chk("illegal_relock", oLocked, 1);

        // glitch shorter than the filter, then a real change with measured latency
        show(7'h07, 10);
        show(7'h3F, 10);
        show(7'h06, 10);
        nv0 = nv; ne0 = ne;
        show(7'h5B, 3);
        show(7'h06, 10);
        chk("glitch_novalid", nv - nv0, 0);
        chk("glitch_noerr", ne - ne0, 0);
        @(negedge CLK);
        iSeg = 7'h5B;
        lat = 0;
        for (int i = 1; i <= 20 && lat == 0; i++) begin
            @(posedge CLK);
            #2;
            if (oValid) lat = i;
        end
        chk("accept_latency", lat, 7);
        repeat (5) @(posedge CLK);
        chk("latency_steps", oStepCnt, 16);

        // digit 8 is out of range for MOD=8
        show(7'h7F, 10);
        chk("range_errcnt", oErrCnt, 3);

        // asynchronous reset mid-stream
        @(posedge CLK);
        #3;
        rst_n = 1'b0;
        iSeg = 7'h00;
        #1;
        chk("async_reset", {oValue, oValid, oLocked, oErr, oErrCnt, oStepCnt}, 32'd0);
        repeat (2) @(negedge CLK);
        rst_n = 1'b1;
        show(7'h00, 10);
`ifdef SEG7_MON_QCHECK_EN
        iQ = 4'd3;
        nmm0 = nmm;
`endif
        show(7'h4F, 10);
        chk("post_reset_value", oValue, 3);
        chk("post_reset_steps", oStepCnt, 0);
        chk("post_reset_locked", oLocked, 1);
        chk("post_reset_errs", oErrCnt, 0);
`ifdef SEG7_MON_QCHECK_EN
        chk("q_match", nmm - nmm0, 0);
        iQ = 4'd5;
        nmm0 = nmm;
        show(7'h66, 10);
        chk("q_mismatch", nmm - nmm0, 1);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
